// File: rtl/dtc_pkg.sv
// Shared constants and types for the DTC slow-control endpoint.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dtc_pkg;

  // Header byte of an incoming slow command, and the two reply headers.
  localparam logic [7:0] SLOWCMD = 8'hE4;
  localparam logic [7:0] HDR_OK  = 8'hE5;
  localparam logic [7:0] HDR_ERR = 8'hE6;

  // Reply frame: {header[7:0], address[31:0], rdata[31:0]}.
  localparam int FRAME_W = 72;
  localparam int CNT_W   = 7;

  // Data returned for a read of a non-existent register.
  localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;

  // Fixed register indices.
  localparam int REG_ID     = 0;
  localparam int REG_STATUS = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/dtc_tx_ser.sv
// Reply serializer: shifts a 72-bit frame out MSB first on dtc_tx.
// Latency: load in cycle N -> bit 71 in N+1, bit 0 in N+72, idle in N+73.
// Backpressure: none; load is ignored while busy, caller must gate it.
// Ports: dtc_clk_90/rst (sync, active-high), load + frame in, dtc_tx + tx_busy out.
module dtc_tx_ser
  import dtc_pkg::*;
(
  input  logic               dtc_clk_90,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  output logic               dtc_tx,
  output logic               tx_busy
);

  tx_state_e          state_q, state_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge dtc_clk_90) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          sh_d    = frame;
          cnt_d   = CNT_W'(FRAME_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // cnt_q is the index of the bit currently on the line.
        if (cnt_q == '0) begin
          sh_d    = '0;
          state_d = IDLE;
        end else begin
          sh_d  = sh_q << 1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_busy = (state_q == SHIFT);
  assign dtc_tx  = tx_busy & sh_q[FRAME_W-1];

endmodule

// File: rtl/dtc_slow_ctrl.sv
// Slow-control endpoint: register bank behind the DTC receiver, reads answered as 72-bit serial frames.
// Latency: write visible/pulsed 1 cycle after strobe; reply bit 71 one cycle after read strobe.
// Backpressure: none; reads during a reply or with a write are dropped and counted as errors.
// Ports: dtc_clk_90/rst, address/data/write/read strobes in; cfg_regs image, cfg_wr_pulse, dtc_tx, tx_busy out.
module dtc_slow_ctrl #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] FW_ID    = 32'h0001_0000,
  parameter logic [7:0]  HDR_OK   = 8'hE5,
  parameter logic [7:0]  HDR_ERR  = 8'hE6
) (
  input  logic                   dtc_clk_90,
  input  logic                   rst,
  input  logic [31:0]            address,
  input  logic [31:0]            data,
  input  logic                   write,
  input  logic                   read,
  output logic [NUM_REGS*32-1:0] cfg_regs,
  output logic [NUM_REGS-1:0]    cfg_wr_pulse,
  output logic                   dtc_tx,
  output logic                   tx_busy
);

  import dtc_pkg::*;

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [31:0]         regs_q [2:NUM_REGS-1];
  logic [31:0]         regs_d [2:NUM_REGS-1];
  logic [15:0]         err_q, err_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;

  logic [31:0]         img [NUM_REGS];
  logic [IDX_W-1:0]    idx;
  logic                addr_ok, wr_ok, wr_err, rd_take, rd_err;
  logic [16:0]         err_sum;
  logic [FRAME_W-1:0]  frame;

  assign idx     = address[IDX_W-1:0];
  assign addr_ok = (address[30:16] == 15'd0) && (address[15:0] < 16'(NUM_REGS));
  assign wr_ok   = write && addr_ok && (address[15:0] > 16'(REG_STATUS));
  assign wr_err  = write && !wr_ok;
  // A simultaneous write always wins; the read is only taken when the line is free.
  assign rd_take = read && !write && !tx_busy;
  assign rd_err  = read && (!rd_take || !addr_ok);

  // Live view of every register, including the constant ID and computed status.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) img[k] = '0;
    img[REG_ID]     = FW_ID;
    img[REG_STATUS] = {err_q, 15'd0, tx_busy};
    for (int k = 2; k < NUM_REGS; k++) img[k] = regs_q[k];
  end

  always_comb begin
    cfg_regs = '0;
    for (int k = 0; k < NUM_REGS; k++) cfg_regs[32*k +: 32] = img[k];
  end

  always_comb begin
    pulse_d = '0;
    if (wr_ok) pulse_d[idx] = 1'b1;
    for (int k = 2; k < NUM_REGS; k++) regs_d[k] = pulse_d[k] ? data : regs_q[k];
  end

  // A write error and a read error in the same cycle count as two offences.
  always_comb begin
    err_sum = {1'b0, err_q} + 17'(wr_err) + 17'(rd_err);
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Read data is captured into the frame at the strobe cycle.
  assign frame = addr_ok ? {HDR_OK, address, img[idx]}
                         : {HDR_ERR, address, RD_ERR_DATA};

  always_ff @(posedge dtc_clk_90) begin
    if (rst) begin
      for (int k = 2; k < NUM_REGS; k++) regs_q[k] <= '0;
      err_q   <= '0;
      pulse_q <= '0;
    end else begin
      for (int k = 2; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
      err_q   <= err_d;
      pulse_q <= pulse_d;
    end
  end

  assign cfg_wr_pulse = pulse_q;

  dtc_tx_ser u_tx_ser (
    .dtc_clk_90 (dtc_clk_90),
    .rst        (rst),
    .load       (rd_take),
    .frame      (frame),
    .dtc_tx     (dtc_tx),
    .tx_busy    (tx_busy)
  );

endmodule

// File: tb/tb_dtc_slow_ctrl.sv
module tb_dtc_slow_ctrl;

  logic          dtc_clk_90 = 1'b0;
  logic          rst;
  logic [31:0]   address;
  logic [31:0]   data;
  logic          write;
  logic          read;
  logic [511:0]  cfg_regs;
  logic [15:0]   cfg_wr_pulse;
  logic          dtc_tx;
  logic          tx_busy;

  int n_chk  = 0;
  int n_pass = 0;

  dtc_slow_ctrl dut (
    .dtc_clk_90   (dtc_clk_90),
    .rst          (rst),
    .address      (address),
    .data         (data),
    .write        (write),
    .read         (read),
    .cfg_regs     (cfg_regs),
    .cfg_wr_pulse (cfg_wr_pulse),
    .dtc_tx       (dtc_tx),
    .tx_busy      (tx_busy)
  );

  always #5 dtc_clk_90 = ~dtc_clk_90;

  task automatic tick();
    @(posedge dtc_clk_90);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Call while the read strobe is driven in cycle N. Returns in cycle N+73
  // with the 72 bits seen on dtc_tx over N+1..N+72 and the busy-cycle count.
  // With hooks set, also writes reg 2 in N+1 and issues a read in N+10.
  task automatic recv(output logic [71:0] f, output int nb, input bit hooks);
    tick();
    read = 1'b0;
    nb = 0;
    f = '0;
    for (int c = 1; c <= 72; c++) begin
      f[72-c] = dtc_tx;
      if (tx_busy) nb++;
      if (hooks) begin
        if (c == 1)  begin write = 1'b1; address = 32'd2; data = 32'h1111_2222; end
        if (c == 2)  write = 1'b0;
        if (c == 10) begin read = 1'b1; address = 32'd3; end
        if (c == 11) read = 1'b0;
      end
      tick();
    end
  endtask

  logic [71:0] fr;
  int          nb;

  initial begin
    rst = 1'b1; address = '0; data = '0; write = 1'b0; read = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_reg2",   72'(cfg_regs[95:64]), 72'h0);
    chk("rst_pulse",  72'(cfg_wr_pulse), 72'h0);
    chk("rst_txbusy", {70'h0, dtc_tx, tx_busy}, 72'h0);
    chk("rst_status", 72'(cfg_regs[63:32]), 72'h0);
    chk("rst_id",     72'(cfg_regs[31:0]), 72'h0001_0000);

    // Write reg 2: visible and pulsed for exactly one cycle
    write = 1'b1; address = 32'd2; data = 32'hCAFE_0001;
    tick();
    write = 1'b0;
    chk("wr2_val",    72'(cfg_regs[95:64]), 72'hCAFE_0001);
    chk("wr2_pulse",  72'(cfg_wr_pulse), 72'h0004);
    tick();
    chk("wr2_pulse_off", 72'(cfg_wr_pulse), 72'h0);
    chk("wr2_hold",   72'(cfg_regs[95:64]), 72'hCAFE_0001);

    // Read ID register
    read = 1'b1; address = 32'h8000_0000;
    recv(fr, nb, 1'b0);
    chk("rd0_frame",  fr, 72'hE5_8000_0000_0001_0000);
    chk("rd0_busy_n", 72'(nb), 72'd72);
    chk("rd0_end",    {70'h0, dtc_tx, tx_busy}, 72'h0);
    chk("rd0_err",    72'(cfg_regs[63:48]), 72'h0);

    // Invalid read
    read = 1'b1; address = 32'd20;
    recv(fr, nb, 1'b0);
    chk("rdbad_frame", fr, 72'hE6_0000_0014_DEAD_BEEF);
    chk("rdbad_err",   72'(cfg_regs[63:48]), 72'h1);

    // Read reg 2 with a write to it in N+1 and a colliding read in N+10
    read = 1'b1; address = 32'd2;
    recv(fr, nb, 1'b1);
    chk("rdcol_frame", fr, 72'hE5_0000_0002_CAFE_0001);
    chk("rdcol_busy_n", 72'(nb), 72'd72);
    chk("rdcol_err",   72'(cfg_regs[63:48]), 72'h2);
    chk("rdcol_wr",    72'(cfg_regs[95:64]), 72'h1111_2222);
    chk("rdcol_idle",  72'(tx_busy), 72'h0);
    // Read in N+73 is accepted
    read = 1'b1; address = 32'd2;
    recv(fr, nb, 1'b0);
    chk("rdnext_frame", fr, 72'hE5_0000_0002_1111_2222);

    // Simultaneous write and read
    write = 1'b1; read = 1'b1; address = 32'd5; data = 32'hA5A5_A5A5;
    tick();
    write = 1'b0; read = 1'b0;
    chk("wrrd_val",   72'(cfg_regs[191:160]), 72'hA5A5_A5A5);
    chk("wrrd_pulse", 72'(cfg_wr_pulse), 72'h0020);
    chk("wrrd_busy",  {70'h0, dtc_tx, tx_busy}, 72'h0);
    chk("wrrd_err",   72'(cfg_regs[63:48]), 72'h3);
    tick();
    chk("wrrd_busy2", 72'(tx_busy), 72'h0);

    // Error counter saturation via 65540 rejected writes (idx 0, idx 1, bad high bits)
    write = 1'b1; data = 32'hFFFF_FFFF;
    for (int i = 0; i < 65540; i++) begin
      case (i % 3)
        0:       address = 32'd0;
        1:       address = 32'd1;
        default: address = 32'h0001_0002;
      endcase
      tick();
      if (i == 65530) chk("sat_fffe", 72'(cfg_regs[63:48]), 72'hFFFE);
      if (i == 65531) chk("sat_ffff", 72'(cfg_regs[63:48]), 72'hFFFF);
      if (i == 100)   chk("sat_nopulse", 72'(cfg_wr_pulse), 72'h0);
    end
    write = 1'b0;
    chk("sat_hold",  72'(cfg_regs[63:48]), 72'hFFFF);
    chk("sat_id",    72'(cfg_regs[31:0]), 72'h0001_0000);
    chk("sat_reg2",  72'(cfg_regs[95:64]), 72'h1111_2222);

    // Reset in the middle of a frame (at bit 30, cycle N+42)
    read = 1'b1; address = 32'd5;
    tick();
    read = 1'b0;
    for (int c = 1; c < 42; c++) tick();
    chk("mid_bit30", 72'({dtc_tx, tx_busy}), 72'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_txbusy", {70'h0, dtc_tx, tx_busy}, 72'h0);
    chk("mid_regs",   72'(|cfg_regs[511:64]), 72'h0);
    chk("mid_err",    72'(cfg_regs[63:32]), 72'h0);
    tick();
    chk("mid_idle",   {70'h0, dtc_tx, tx_busy}, 72'h0);

    // Full frame after reset
    write = 1'b1; address = 32'd7; data = 32'h1357_9BDF;
    tick();
    write = 1'b0;
    read = 1'b1; address = 32'd7;
    recv(fr, nb, 1'b0);
    chk("post_frame",  fr, 72'hE5_0000_0007_1357_9BDF);
    chk("post_busy_n", 72'(nb), 72'd72);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
